dm_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port data memory of the MIPS CPU. It shares one word-addressed RAM between the CPU load/store port (requester 0) and a loader/DMA port (requester 1). It uses round-robin priority, an optional lock for back-to-back ownership, out-of-range protection and a registered read-response path. It sits between the core's MEM stage / loader logic and the RAM array.

---
 rtl/dm_arbiter.sv | 156 +++++++++++++++
 tb/tb_dm_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one word-addressed data RAM between the CPU load/store
// port (requester 0) and the loader/DMA port (requester 1). Round-robin
// arbitration with an optional ownership lock, out-of-range protection and a
// registered one-cycle response path.
module dm_arbiter #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  input  logic [3:0]    be0,
  input  logic [3:0]    be1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          ram_we,
  output logic [AW-1:0] ram_idx,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_be,
  input  logic [31:0]   ram_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;

  logic          granted;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_be;
  logic [AW-1:0] word_idx;
  logic          in_range;

  logic          rv0_q, rv1_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [15:0]   cnt_q;

  // State and round-robin pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Grant decision and next state; lock exit is decided after this cycle's grant
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            if (prio_q) gnt1 = 1'b1;
            else        gnt0 = 1'b1;
            prio_d = ~prio_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
          if (gnt0 && lock0)      state_d = OWN0;
          else if (gnt1 && lock1) state_d = OWN1;
        end
        OWN0: begin
          gnt0 = req0;
          if (!lock0) begin
            state_d = IDLE;
            prio_d  = 1'b1;
          end
        end
        OWN1: begin
          gnt1 = req1;
          if (!lock1) begin
            state_d = IDLE;
            prio_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Winner mux and RAM-side drive; idle cycles drive all-zero
  always_comb begin
    granted   = gnt0 | gnt1;
    sel_we    = gnt1 ? we1    : we0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    sel_be    = gnt1 ? be1    : be0;
    word_idx  = sel_addr[AW+1:2];
    in_range  = {{(32-AW){1'b0}}, word_idx} < DEPTH_W;
    ram_we    = granted & sel_we & in_range;
    ram_idx   = granted ? word_idx  : '0;
    ram_wdata = granted ? sel_wdata : '0;
    ram_be    = granted ? sel_be    : '0;
  end

  // Response registers: capture read data and range error at grant
  always_ff @(posedge clk) begin
    if (reset) begin
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rv0_q   <= gnt0;
      rv1_q   <= gnt1;
      err_q   <= granted & ~in_range;
      rdata_q <= (granted && !sel_we && in_range) ? ram_rdata : '0;
    end
  end

  // Saturating count of cycles with both requests high
  always_ff @(posedge clk) begin
    if (reset)                           cnt_q <= '0;
    else if (req0 && req1 && cnt_q != '1) cnt_q <= cnt_q + 16'd1;
  end

  // Registered outputs are masked so a reset cycle shows reset values at once
  always_comb begin
    rvalid0      = rv0_q & ~reset;
    rvalid1      = rv1_q & ~reset;
    err          = err_q & ~reset;
    rdata        = reset ? '0 : rdata_q;
    conflict_cnt = reset ? '0 : cnt_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus a randomized run checked
// against a behavioural model (owner index, priority bit, memory image).
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err, ram_we;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic [11:0] ram_idx;
  logic [3:0]  ram_be;
  logic [15:0] conflict_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.DEPTH(3072), .AW(12)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .be0(be0), .be1(be1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err), .ram_we(ram_we), .ram_idx(ram_idx),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Environment RAM (4096 entries so out-of-range indices still read safely)
  logic [31:0] ram [0:4095];
  assign ram_rdata = ram[ram_idx];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  int          m_own;         // -1: no owner, else locked requester
  logic        m_prio;
  logic        m_pv0, m_pv1, m_perr;
  logic [31:0] m_prd;
  int unsigned m_cnt;
  logic [31:0] mmem [0:4095];

  logic        e_g0, e_g1, w_we, e_inr, e_any;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_be;
  int unsigned e_idx;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!reset) begin
      if (m_own == 0)           e_g0 = req0;
      else if (m_own == 1)      e_g1 = req1;
      else if (req0 && req1)    begin e_g0 = !m_prio; e_g1 = m_prio; end
      else                      begin e_g0 = req0; e_g1 = req1; end
    end
    e_any   = e_g0 | e_g1;
    w_we    = e_g1 ? we1 : we0;
    w_addr  = e_g1 ? addr1 : addr0;
    w_wdata = e_g1 ? wdata1 : wdata0;
    w_be    = e_g1 ? be1 : be0;
    e_idx   = (w_addr / 4) % 4096;
    e_inr   = e_idx < 3072;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_own <= -1; m_prio <= 1'b0; m_pv0 <= 1'b0; m_pv1 <= 1'b0;
      m_perr <= 1'b0; m_prd <= '0; m_cnt <= 0;
    end else begin
      if (req0 && req1 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      m_pv0  <= e_g0;
      m_pv1  <= e_g1;
      m_perr <= e_any && !e_inr;
      m_prd  <= (e_any && !w_we && e_inr) ? mmem[e_idx] : 32'h0;
      if (e_any && w_we && e_inr) mmem[e_idx] <= merge(mmem[e_idx], w_wdata, w_be);
      if (m_own < 0) begin
        if (req0 && req1) m_prio <= !m_prio;
        if (e_g0 && lock0)      m_own <= 0;
        else if (e_g1 && lock1) m_own <= 1;
      end else if (m_own == 0 && !lock0) begin
        m_own <= -1; m_prio <= 1'b1;
      end else if (m_own == 1 && !lock1) begin
        m_own <= -1; m_prio <= 1'b0;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'($urandom_range(0, 7)) << 2;
      1:       a = 32'($urandom_range(3068, 3075)) << 2;
      2:       a = $urandom;
      default: a = 32'($urandom_range(0, 15)) << 2;
    endcase
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1;
    req0 = 1; req1 = 1;
    tick();
    #1;
    vectors++; if ({gnt1, gnt0} !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got %b want 00", {gnt1, gnt0}); end
    vectors++; if ({rvalid1, rvalid0, err, ram_we} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {rvalid1, rvalid0, err, ram_we}); end
    vectors++; if ({rdata, ram_wdata, ram_idx, ram_be, conflict_cnt} !== '0) begin miscompares++; $display("FAIL reset_buses got %h want 0", {rdata, ram_wdata, ram_idx, ram_be, conflict_cnt}); end
    tick();
    do_reset();
  endtask

  task automatic test_single_rw();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; be0 = 4'hF;
    #1;
    vectors++; if ({gnt1, gnt0} !== 2'b01) begin miscompares++; $display("FAIL wr_gnt got %b want 01", {gnt1, gnt0}); end
    vectors++; if ({ram_we, ram_idx, ram_be, ram_wdata} !== {1'b1, 12'd4, 4'hF, 32'hDEADBEEF}) begin miscompares++; $display("FAIL wr_ram got %h want %h", {ram_we, ram_idx, ram_be, ram_wdata}, {1'b1, 12'd4, 4'hF, 32'hDEADBEEF}); end
    tick();
    clear_inputs();
    req1 = 1; we1 = 0; addr1 = 32'h10;
    #1;
    vectors++; if ({rvalid1, rvalid0, err, rdata} !== {3'b010, 32'h0}) begin miscompares++; $display("FAIL wr_resp got %h want %h", {rvalid1, rvalid0, err, rdata}, {3'b010, 32'h0}); end
    vectors++; if ({gnt1, gnt0, ram_we} !== 3'b100) begin miscompares++; $display("FAIL rd_gnt got %b want 100", {gnt1, gnt0, ram_we}); end
    tick();
    clear_inputs();
    #1;
    vectors++; if ({rvalid1, rvalid0, err, rdata} !== {3'b100, 32'hDEADBEEF}) begin miscompares++; $display("FAIL rd_resp got %h want %h", {rvalid1, rvalid0, err, rdata}, {3'b100, 32'hDEADBEEF}); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 32'h4; addr1 = 32'h8;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({gnt1, gnt0} !== want[i]) begin miscompares++; $display("FAIL contention_gnt%0d got %b want %b", i, {gnt1, gnt0}, want[i]); end
      tick();
    end
    clear_inputs();
    #1;
    vectors++; if (conflict_cnt !== 16'd4) begin miscompares++; $display("FAIL contention_cnt got %0d want 4", conflict_cnt); end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    lock0 = 1; addr0 = 32'h4;
    #1;
    vectors++; if ({gnt1, gnt0} !== 2'b00) begin miscompares++; $display("FAIL lock_noreq got %b want 00", {gnt1, gnt0}); end
    tick();
    lock0 = 0;
    req1 = 1; lock1 = 1; addr1 = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({gnt1, gnt0} !== 2'b10) begin miscompares++; $display("FAIL lock_own%0d got %b want 10", i, {gnt1, gnt0}); end
      tick();
      req0 = 1;
    end
    req1 = 0;
    #1;
    vectors++; if ({gnt1, gnt0} !== 2'b00) begin miscompares++; $display("FAIL lock_hold_noreq got %b want 00", {gnt1, gnt0}); end
    tick();
    lock1 = 0;
    #1;
    vectors++; if ({gnt1, gnt0} !== 2'b00) begin miscompares++; $display("FAIL lock_exit_cycle got %b want 00", {gnt1, gnt0}); end
    tick();
    #1;
    vectors++; if ({gnt1, gnt0} !== 2'b01) begin miscompares++; $display("FAIL lock_after got %b want 01", {gnt1, gnt0}); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_byte_range();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h11223344; be0 = 4'hF;
    tick();
    wdata0 = 32'hAABBCCDD; be0 = 4'b0101;
    tick();
    we0 = 0; be0 = 4'h0;
    tick();
    clear_inputs();
    #1;
    vectors++; if ({rvalid0, err, rdata} !== {2'b10, 32'h11BB33DD}) begin miscompares++; $display("FAIL be_merge got %h want %h", {rvalid0, err, rdata}, {2'b10, 32'h11BB33DD}); end
    req1 = 1; we1 = 1; addr1 = 32'h3000; wdata1 = 32'hCAFEF00D; be1 = 4'hF;
    #1;
    vectors++; if ({gnt1, ram_we, ram_idx} !== {2'b10, 12'd3072}) begin miscompares++; $display("FAIL oor_wr got %h want %h", {gnt1, ram_we, ram_idx}, {2'b10, 12'd3072}); end
    tick();
    addr1 = 32'h2FFC; wdata1 = 32'h01020304;
    #1;
    vectors++; if ({rvalid1, err, rdata} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL oor_wr_resp got %h want %h", {rvalid1, err, rdata}, {2'b11, 32'h0}); end
    vectors++; if ({ram_we, ram_idx} !== {1'b1, 12'd3071}) begin miscompares++; $display("FAIL last_word_wr got %h want %h", {ram_we, ram_idx}, {1'b1, 12'd3071}); end
    tick();
    we1 = 0; addr1 = 32'h3000;
    #1;
    vectors++; if ({rvalid1, err} !== 2'b10) begin miscompares++; $display("FAIL last_word_resp got %b want 10", {rvalid1, err}); end
    tick();
    clear_inputs();
    #1;
    vectors++; if ({rvalid1, err, rdata} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL oor_rd_resp got %h want %h", {rvalid1, err, rdata}, {2'b11, 32'h0}); end
    tick();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    req1 = 1; lock1 = 1; addr1 = 32'h10;
    tick();
    req0 = 1; reset = 1;
    #1;
    vectors++; if ({gnt1, gnt0, rvalid1, rvalid0, err, ram_we} !== 6'b0) begin miscompares++; $display("FAIL rst_lock_flags got %b want 000000", {gnt1, gnt0, rvalid1, rvalid0, err, ram_we}); end
    vectors++; if ({rdata, ram_idx, ram_wdata, ram_be, conflict_cnt} !== '0) begin miscompares++; $display("FAIL rst_lock_buses got %h want 0", {rdata, ram_idx, ram_wdata, ram_be, conflict_cnt}); end
    tick();
    reset = 0; lock1 = 0;
    #1;
    vectors++; if ({rvalid1, rvalid0} !== 2'b00) begin miscompares++; $display("FAIL rst_lock_rvalid got %b want 00", {rvalid1, rvalid0}); end
    vectors++; if ({gnt1, gnt0} !== 2'b01) begin miscompares++; $display("FAIL rst_lock_first got %b want 01", {gnt1, gnt0}); end
    tick();
    #1;
    vectors++; if ({gnt1, gnt0} !== 2'b10) begin miscompares++; $display("FAIL rst_lock_second got %b want 10", {gnt1, gnt0}); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic h0 = 1'b0, h1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!h0) begin
        req0 = ($urandom_range(0, 2) != 0); we0 = 1'($urandom_range(0, 1));
        addr0 = rand_addr(); wdata0 = $urandom; be0 = 4'($urandom_range(0, 15));
      end
      if (!h1) begin
        req1 = ($urandom_range(0, 2) != 0); we1 = 1'($urandom_range(0, 1));
        addr1 = rand_addr(); wdata1 = $urandom; be1 = 4'($urandom_range(0, 15));
      end
      lock0 = ($urandom_range(0, 3) == 0);
      lock1 = ($urandom_range(0, 3) == 0);
      #1;
      vectors++; if ({gnt1, gnt0} !== {e_g1, e_g0}) begin miscompares++; $display("FAIL rnd_gnt[%0d] got %b want %b", i, {gnt1, gnt0}, {e_g1, e_g0}); end
      vectors++; if (ram_we !== (e_any && w_we && e_inr)) begin miscompares++; $display("FAIL rnd_ram_we[%0d] got %b want %b", i, ram_we, e_any && w_we && e_inr); end
      vectors++; if (ram_idx !== (e_any ? 12'(e_idx) : 12'h0)) begin miscompares++; $display("FAIL rnd_ram_idx[%0d] got %h want %h", i, ram_idx, e_any ? 12'(e_idx) : 12'h0); end
      vectors++; if ({ram_wdata, ram_be} !== (e_any ? {w_wdata, w_be} : 36'h0)) begin miscompares++; $display("FAIL rnd_ram_data[%0d] got %h want %h", i, {ram_wdata, ram_be}, e_any ? {w_wdata, w_be} : 36'h0); end
      vectors++; if ({rvalid1, rvalid0, err} !== (reset ? 3'b0 : {m_pv1, m_pv0, m_perr})) begin miscompares++; $display("FAIL rnd_resp[%0d] got %b want %b", i, {rvalid1, rvalid0, err}, reset ? 3'b0 : {m_pv1, m_pv0, m_perr}); end
      vectors++; if (rdata !== (reset ? 32'h0 : m_prd)) begin miscompares++; $display("FAIL rnd_rdata[%0d] got %h want %h", i, rdata, reset ? 32'h0 : m_prd); end
      vectors++; if (conflict_cnt !== (reset ? 16'h0 : 16'(m_cnt))) begin miscompares++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, conflict_cnt, reset ? 0 : m_cnt); end
      h0 = req0 && !e_g0;
      h1 = req1 && !e_g1;
      tick();
    end
    reset = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = '0;
      mmem[i] = '0;
    end
    clear_inputs();
    reset = 1;
    tick();
    test_reset();
    test_single_rw();
    test_contention();
    test_lock();
    test_byte_range();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
